// File: rtl/fir_pkg.sv
// Constants and types shared by the FIR filter and its coefficient loader.
package fir_pkg;

  localparam int NUM_TAPS = 10;
  localparam int COEFF_W  = 16;
  localparam int TAP_AW   = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    PEND = 2'd2
  } ldr_state_e;

  typedef logic [NUM_TAPS-1:0][COEFF_W-1:0] coeff_bank_t;

  // Host tap addresses are 1-based.
  function automatic logic tap_addr_legal(input logic [TAP_AW-1:0] addr);
    return (addr >= TAP_AW'(1)) && (addr <= TAP_AW'(NUM_TAPS));
  endfunction

endpackage

// File: rtl/fir_coeff_loader_coeff_bank.sv
// Shadow/active coefficient storage with per-tap written mask.
// A swap copies the whole shadow bank to the active bank in a single edge.
module coeff_bank
  import fir_pkg::*;
(
  input  logic                clk,
  input  logic                rst,
  input  logic                wr_en,
  input  logic [TAP_AW-1:0]   wr_idx,
  input  logic [COEFF_W-1:0]  wr_data,
  input  logic                swap_en,
  output coeff_bank_t         active,
  output logic                mask_full_nxt
);

  coeff_bank_t               shadow_q, shadow_d;
  coeff_bank_t               active_q, active_d;
  logic [NUM_TAPS-1:0]       mask_q, mask_d;

  always_comb begin
    shadow_d = shadow_q;
    active_d = active_q;
    mask_d   = mask_q;
    for (int i = 0; i < NUM_TAPS; i++) begin
      if (wr_en && (wr_idx == TAP_AW'(i))) begin
        shadow_d[i] = wr_data;
        mask_d[i]   = 1'b1;
      end
    end
    // Writes are blocked while a swap is pending, so the two never collide.
    if (swap_en) begin
      active_d = shadow_q;
      mask_d   = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      shadow_q <= '0;
      active_q <= '0;
      mask_q   <= '0;
    end else begin
      shadow_q <= shadow_d;
      active_q <= active_d;
      mask_q   <= mask_d;
    end
  end

  assign active        = active_q;
  assign mask_full_nxt = &mask_d;

endmodule

// File: rtl/fir_coeff_loader.sv
// Host write front-end for the FIR coefficients: shadow loading, commit
// handshake and a strobe-aligned swap so the filter never sees a mixed set.
module fir_coeff_loader
  import fir_pkg::*;
(
  input  logic               iClk_12M,
  input  logic               iRst,
  input  logic               iEnSample_300k,
  input  logic               iCoeffValid,
  input  logic [TAP_AW-1:0]  iCoeffAddr,
  input  logic [COEFF_W-1:0] iCoeffData,
  output logic               oCoeffReady,
  input  logic               iCommit,
  output logic [COEFF_W-1:0] oCoeff1,
  output logic [COEFF_W-1:0] oCoeff2,
  output logic [COEFF_W-1:0] oCoeff3,
  output logic [COEFF_W-1:0] oCoeff4,
  output logic [COEFF_W-1:0] oCoeff5,
  output logic [COEFF_W-1:0] oCoeff6,
  output logic [COEFF_W-1:0] oCoeff7,
  output logic [COEFF_W-1:0] oCoeff8,
  output logic [COEFF_W-1:0] oCoeff9,
  output logic [COEFF_W-1:0] oCoeff10,
  output logic               oBusy,
  output logic               oSwapDone,
  output logic               oErr
);

  ldr_state_e          state_q, state_d;
  logic                err_q, err_d;
  logic                swap_done_q, swap_done_d;

  logic                wr_acc;
  logic                addr_ok;
  logic                wr_en;
  logic                swap_en;
  logic                mask_full_nxt;
  logic [TAP_AW-1:0]   wr_idx;
  coeff_bank_t         active;

  assign addr_ok = tap_addr_legal(iCoeffAddr);
  assign wr_acc  = iCoeffValid && oCoeffReady;
  assign wr_en   = wr_acc && addr_ok;
  assign wr_idx  = iCoeffAddr - TAP_AW'(1);

  coeff_bank u_bank (
    .clk           (iClk_12M),
    .rst           (iRst),
    .wr_en         (wr_en),
    .wr_idx        (wr_idx),
    .wr_data       (iCoeffData),
    .swap_en       (swap_en),
    .active        (active),
    .mask_full_nxt (mask_full_nxt)
  );

  always_ff @(posedge iClk_12M) begin
    if (iRst) begin
      state_q     <= IDLE;
      err_q       <= 1'b0;
      swap_done_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      err_q       <= err_d;
      swap_done_q <= swap_done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (wr_en) state_d = LOAD;
      LOAD:    if (iCommit && mask_full_nxt) state_d = PEND;
      PEND:    if (iEnSample_300k) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    oCoeffReady = (state_q != PEND);
    // Busy stays up through the swap-done cycle so both drop together.
    oBusy       = (state_q == PEND) || swap_done_q;
    oSwapDone   = swap_done_q;
    oErr        = err_q;
    swap_en     = (state_q == PEND) && iEnSample_300k;
    swap_done_d = swap_en;

    err_d = err_q;
    if (wr_acc) begin
      err_d = !addr_ok;
    end
    if ((state_q == LOAD) && iCommit && !mask_full_nxt) begin
      err_d = 1'b1;
    end
  end

  assign oCoeff1  = active[0];
  assign oCoeff2  = active[1];
  assign oCoeff3  = active[2];
  assign oCoeff4  = active[3];
  assign oCoeff5  = active[4];
  assign oCoeff6  = active[5];
  assign oCoeff7  = active[6];
  assign oCoeff8  = active[7];
  assign oCoeff9  = active[8];
  assign oCoeff10 = active[9];

endmodule

// File: tb/tb_fir_coeff_loader.sv
// Directed bench for fir_coeff_loader: reset, loading, commit/swap timing,
// error handling, write blocking while pending, and reset during a pending swap.
module tb_fir_coeff_loader;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        en_sample = 1'b0;
  logic        cvalid = 1'b0;
  logic [3:0]  caddr = '0;
  logic [15:0] cdata = '0;
  logic        cready;
  logic        commit = 1'b0;
  logic [15:0] c1, c2, c3, c4, c5, c6, c7, c8, c9, c10;
  logic        busy, swap_done, err;

  int checks = 0;
  int errors = 0;

  logic [9:0][15:0] set_a, set_b, set_c, set_d, zeros;

  always #5 clk = ~clk;

  fir_coeff_loader dut (
    .iClk_12M       (clk),
    .iRst           (rst),
    .iEnSample_300k (en_sample),
    .iCoeffValid    (cvalid),
    .iCoeffAddr     (caddr),
    .iCoeffData     (cdata),
    .oCoeffReady    (cready),
    .iCommit        (commit),
    .oCoeff1        (c1),
    .oCoeff2        (c2),
    .oCoeff3        (c3),
    .oCoeff4        (c4),
    .oCoeff5        (c5),
    .oCoeff6        (c6),
    .oCoeff7        (c7),
    .oCoeff8        (c8),
    .oCoeff9        (c9),
    .oCoeff10       (c10),
    .oBusy          (busy),
    .oSwapDone      (swap_done),
    .oErr           (err)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [159:0] obs, input logic [159:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [159:0] coeffs();
    return {c10, c9, c8, c7, c6, c5, c4, c3, c2, c1};
  endfunction

  task automatic wr(input int a, input logic [15:0] d);
    cvalid = 1'b1;
    caddr  = 4'(a);
    cdata  = d;
    step();
    cvalid = 1'b0;
  endtask

  task automatic wr_bank(input logic [9:0][15:0] b, input int n);
    for (int k = 1; k <= n; k++) wr(k, b[k-1]);
  endtask

  task automatic pulse_commit();
    commit = 1'b1;
    step();
    commit = 1'b0;
  endtask

  task automatic pulse_strobe();
    en_sample = 1'b1;
    step();
    en_sample = 1'b0;
  endtask

  initial begin
    zeros = '0;
    set_a = {16'hFFF6, 16'h0009, 16'hFFF8, 16'h0007, 16'hFFFA,
             16'h0005, 16'hFFFC, 16'h0003, 16'hFFFE, 16'h0001};
    set_b = {16'h010A, 16'h0109, 16'h0108, 16'h0107, 16'h0106,
             16'h0105, 16'h0104, 16'h0103, 16'h0102, 16'h0101};
    set_c = {16'h0C0A, 16'h0C09, 16'h0C08, 16'h0C07, 16'h0C06,
             16'h0C05, 16'h0C04, 16'h0C03, 16'h8000, 16'h7FFF};
    set_d = {16'hFFF6, 16'h0009, 16'hFFF8, 16'h0007, 16'hFFFA,
             16'h0005, 16'hFFFC, 16'h0333, 16'hFFFE, 16'h0001};

    // Reset
    step();
    step();
    rst = 1'b0;
    chk("rst_coeffs", coeffs(), zeros);
    chk("rst_ready", cready, 1'b1);
    chk("rst_busy", busy, 1'b0);
    chk("rst_err", err, 1'b0);
    chk("rst_swapdone", swap_done, 1'b0);

    // Full load, commit, strobe five cycles later
    wr_bank(set_a, 10);
    chk("load_busy", busy, 1'b0);
    chk("load_coeffs_hidden", coeffs(), zeros);
    pulse_commit();
    chk("commit_busy", busy, 1'b1);
    chk("pend_ready", cready, 1'b0);
    for (int i = 0; i < 4; i++) step();
    chk("pend_busy_hold", busy, 1'b1);
    chk("pend_coeffs_old", coeffs(), zeros);
    en_sample = 1'b1;
    #1;
    chk("strobe_pre_edge_old", coeffs(), zeros);
    step();
    en_sample = 1'b0;
    chk("swap_coeffs_a", coeffs(), set_a);
    chk("swap_done_pulse", swap_done, 1'b1);
    chk("swap_busy_tail", busy, 1'b1);
    step();
    chk("swap_done_once", swap_done, 1'b0);
    chk("swap_busy_low", busy, 1'b0);

    // Incomplete mask commit
    wr_bank(set_b, 9);
    pulse_commit();
    chk("partial_err", err, 1'b1);
    chk("partial_busy", busy, 1'b0);
    chk("partial_ready", cready, 1'b1);
    pulse_strobe();
    chk("partial_no_swap", coeffs(), set_a);
    chk("partial_no_done", swap_done, 1'b0);
    // Last write and commit in the same cycle
    cvalid = 1'b1;
    caddr  = 4'd10;
    cdata  = set_b[9];
    commit = 1'b1;
    step();
    cvalid = 1'b0;
    commit = 1'b0;
    chk("wr_commit_busy", busy, 1'b1);
    chk("wr_commit_err_clr", err, 1'b0);
    step();
    step();
    pulse_strobe();
    chk("swap_coeffs_b", coeffs(), set_b);
    chk("swap_b_done", swap_done, 1'b1);
    step();

    // Commit coincident with strobe
    wr_bank(set_c, 10);
    commit    = 1'b1;
    en_sample = 1'b1;
    step();
    commit    = 1'b0;
    en_sample = 1'b0;
    chk("coinc_busy", busy, 1'b1);
    chk("coinc_no_done", swap_done, 1'b0);
    chk("coinc_no_swap", coeffs(), set_b);
    step();
    step();
    chk("coinc_still_b", coeffs(), set_b);
    pulse_strobe();
    chk("swap_coeffs_c", coeffs(), set_c);
    chk("swap_c_done", swap_done, 1'b1);
    step();
    chk("swap_c_busy_low", busy, 1'b0);

    // Write held off while pending
    wr_bank(set_a, 10);
    pulse_commit();
    cvalid = 1'b1;
    caddr  = 4'd3;
    cdata  = 16'h0333;
    chk("hold_ready_low", cready, 1'b0);
    step();
    step();
    chk("hold_ready_low2", cready, 1'b0);
    pulse_strobe();
    chk("hold_swap_a", coeffs(), set_a);
    chk("hold_ready_idle", cready, 1'b1);
    step();
    cvalid = 1'b0;
    pulse_commit();
    chk("hold_write_taken", err, 1'b1);
    wr(1, set_a[0]);
    wr(2, set_a[1]);
    for (int k = 4; k <= 10; k++) wr(k, set_a[k-1]);
    chk("refill_err_clr", err, 1'b0);
    pulse_commit();
    chk("refill_busy", busy, 1'b1);
    pulse_strobe();
    chk("swap_coeffs_d", coeffs(), set_d);
    step();

    // Illegal addresses
    wr(0, 16'h7FFF);
    chk("addr0_err", err, 1'b1);
    chk("addr0_ready", cready, 1'b1);
    wr(11, 16'h1234);
    chk("addr11_err", err, 1'b1);
    wr(15, 16'h5678);
    chk("addr15_err", err, 1'b1);
    pulse_commit();
    chk("idle_commit_ignored", busy, 1'b0);
    chk("illegal_no_change", coeffs(), set_d);
    wr(5, 16'h0055);
    chk("legal_err_clr", err, 1'b0);

    // Reset during pending swap
    wr_bank(set_c, 10);
    pulse_commit();
    chk("rstpend_busy", busy, 1'b1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("rstpend_coeffs", coeffs(), zeros);
    chk("rstpend_busy_low", busy, 1'b0);
    chk("rstpend_no_done", swap_done, 1'b0);
    chk("rstpend_ready", cready, 1'b1);
    chk("rstpend_err", err, 1'b0);
    pulse_strobe();
    chk("rstpend_strobe_no_done", swap_done, 1'b0);
    chk("rstpend_strobe_coeffs", coeffs(), zeros);
    step();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
